sensor_frame_buf: RTL and testbench
===================================

# sensor_frame_buf

Parametrised sensor capture controller. It latches complete NCH-channel sensor frames into a DEPTH-frame circular buffer and lets the core read any channel of any buffered frame. The core releases frames in order, and the block raises an interrupt on a programmable fill level. It sits between the sensor array and the core's sensor-control register interface. It supports stop-on-full and overwrite-oldest capture modes, and reports overflow with a sticky flag.

## Interface
- NCH, 8, channels per frame (≥1)
- DW, 32, bits per channel sample
- DEPTH, 4, frames buffered; power of two, ≥2
- IRQ_LEVEL, DEPTH, fill count at which the interrupt asserts; 1..DEPTH
- Derived: CW=max(1,$clog2(NCH)), FW=$clog2(DEPTH), NW=$clog2(DEPTH+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sctrl_en  in  1  capture enable
- sctrl_clear  in  1  flush buffer; clears overflow
- sctrl_pop  in  1  release oldest frame
- sctrl_mode  in  1  0 = stop when full, 1 = overwrite oldest
- sctrl_addr  in  FW+CW  {frame offset from oldest, channel}
- sensor_ready  in  1  frame valid on sensor_data
- sensor_data  in  NCH*DW  channel i at [i*DW +: DW]
- sctrl_out  out  DW  selected sample
- sctrl_count  out  NW  frames buffered
- sctrl_interrupt  out  1  count ≥ IRQ_LEVEL
- sctrl_overflow  out  1  sticky; a frame was overwritten
- sensor_en  out  1  request to sensor

## Operation
- State register, three states:
  - IDLE: sctrl_en=0.
  - ARMED: enabled and (count<DEPTH or mode=1).
  - FULL: enabled, count=DEPTH, mode=0.
- State transitions are re-evaluated every cycle from the next-cycle sctrl_en, count and mode.
- sensor_en = (state≠IDLE) & ~(state==FULL) & sctrl_en & ~sctrl_clear.
- Push = sensor_en & sensor_ready.
  - Push writes all NCH samples to frame slot wr_ptr, then increments wr_ptr modulo DEPTH.
- Pop = sctrl_pop & count>0. It increments rd_ptr modulo DEPTH. Pop with count=0 is ignored.
- Push with count<DEPTH: count+1.
- Push with count=DEPTH (only possible when mode=1): oldest frame is discarded (rd_ptr+1), count stays DEPTH, sctrl_overflow←1.
- Push and pop in the same cycle:
  - count<DEPTH: count unchanged; both pointers advance.
  - count=DEPTH, mode=1: treated as one overwrite plus one pop. rd_ptr+2, count=DEPTH−1, overflow←1.
- Clear has priority over push and pop: pointers, count and overflow go to 0. Sample storage is not reset.
- Read path: sctrl_out = sample[(rd_ptr+offset) mod DEPTH][channel].
  - Returns 0 if offset ≥ count or channel ≥ NCH.
- Changing mode while FULL takes effect the next cycle. Overflow is never cleared by a mode change.

## Timing
- Reset values: sctrl_out 0, sctrl_count 0, sctrl_interrupt 0, sctrl_overflow 0, sensor_en 0, state IDLE, pointers 0.
- Sample storage is zeroed on reset.
- rst mid-capture discards the in-flight push.
- Capture latency: data presented with push at edge N is readable from sctrl_out in cycle N+1. sctrl_count and sctrl_interrupt update in cycle N+1.
- sctrl_out is combinational from sctrl_addr and registered state, with zero-cycle read latency.
- sensor_en is combinational, so it drops in the same cycle as sctrl_clear or sctrl_en falling.
- sensor_ready while sensor_en=0 is ignored.
- sctrl_interrupt is derived from the registered count, so it has no combinational path from inputs.

## Structure
- Package sensor_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, FULL} sctrl_state_t
  - mode constants MODE_STOP=1'b0, MODE_OVERWRITE=1'b1
- Sub-module sensor_frame_ram: DEPTH×NCH×DW storage with synchronous full-frame write, asynchronous single-sample read, and synchronous reset-to-zero.
- Control logic in the top module: FSM, pointers, count, overflow, address decode.

## Test plan
- Reset, then enable, 3 pushes with data 0x100+i per channel i, frame tag k → count=3, interrupt=0, addr {2,5} reads 0x105 of frame 2.
- Mode 0, 4 pushes → count=4, interrupt=1, state FULL, sensor_en=0. A 5th sensor_ready is ignored; overflow=0.
- Mode 1, 6 pushes of frames 0..5 → count=4, overflow=1, addr {0,0} reads frame 2 data. Overflow stays 1 until clear.
- Count=2, simultaneous push and pop → count stays 2, and offset 0 now returns the former offset-1 frame.
- Pop at count=0 → no change. Addr offset 3 at count=2 → sctrl_out=0. Channel index 8 with NCH=8 is unreachable, so check with NCH=6, channel 7 → 0.
- Clear asserted with push and pop in the same cycle → count=0, overflow=0, sensor_en=0 that cycle. Mid-capture rst → all outputs 0 next cycle.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor frame capture buffer.
package sensor_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, FULL} sctrl_state_t;

  localparam logic MODE_STOP      = 1'b0;
  localparam logic MODE_OVERWRITE = 1'b1;

endpackage

// File: rtl/sensor_frame_ram.sv
// DEPTH x NCH x DW frame storage: whole-frame synchronous write, single-sample async read.
module sensor_frame_ram #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned FW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [FW-1:0]       wr_addr_i,
  input  logic [NCH*DW-1:0]   wr_data_i,
  input  logic [FW-1:0]       rd_addr_i,
  input  logic [CW-1:0]       rd_ch_i,
  output logic [DW-1:0]       rd_data_o
);

  logic [NCH*DW-1:0] mem_q [DEPTH];
  logic [NCH*DW-1:0] rd_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_frame = mem_q[rd_addr_i];

  // Channel mux; indices with no channel behind them read as zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch_i == CW'(i)) begin
        rd_data_o = rd_frame[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/sensor_frame_buf.sv
// Sensor capture controller: buffers complete frames in a circular store for the core to read.
module sensor_frame_buf
  import sensor_pkg::*;
#(
  parameter int unsigned NCH       = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IRQ_LEVEL = DEPTH,
  localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned FW       = $clog2(DEPTH),
  localparam int unsigned NW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sctrl_en,
  input  logic                sctrl_clear,
  input  logic                sctrl_pop,
  input  logic                sctrl_mode,
  input  logic [FW+CW-1:0]    sctrl_addr,
  input  logic                sensor_ready,
  input  logic [NCH*DW-1:0]   sensor_data,
  output logic [DW-1:0]       sctrl_out,
  output logic [NW-1:0]       sctrl_count,
  output logic                sctrl_interrupt,
  output logic                sctrl_overflow,
  output logic                sensor_en
);

  sctrl_state_t  state_q, state_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [FW-1:0] rd_off;
  logic [CW-1:0] rd_ch;
  logic [FW-1:0] rd_slot;
  logic          rd_valid;
  logic [DW-1:0] ram_rdata;

  assign full      = (count_q == NW'(DEPTH));
  assign sensor_en = (state_q != IDLE) && (state_q != FULL) && sctrl_en && !sctrl_clear;
  assign push      = sensor_en && sensor_ready;
  assign pop       = sctrl_pop && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (sctrl_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + FW'(1);
      end
      unique case ({push, pop})
        2'b11: begin
          // On a full buffer this is an overwrite plus a pop: the oldest two frames go.
          if (full) begin
            rd_ptr_d = rd_ptr_q + FW'(2);
            count_d  = NW'(DEPTH - 1);
            ovf_d    = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + FW'(1);
          end
        end
        2'b10: begin
          if (full) begin
            rd_ptr_d = rd_ptr_q + FW'(1);
            ovf_d    = 1'b1;
          end else begin
            count_d = count_q + NW'(1);
          end
        end
        2'b01: begin
          rd_ptr_d = rd_ptr_q + FW'(1);
          count_d  = count_q - NW'(1);
        end
        default: ;
      endcase
    end

    if (!sctrl_en) begin
      state_d = IDLE;
    end else if ((count_d == NW'(DEPTH)) && (sctrl_mode == MODE_STOP)) begin
      state_d = FULL;
    end else begin
      state_d = ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Read address is an offset from the oldest frame, not an absolute slot.
  assign rd_off   = sctrl_addr[FW+CW-1:CW];
  assign rd_ch    = sctrl_addr[CW-1:0];
  assign rd_slot  = rd_ptr_q + rd_off;
  assign rd_valid = (NW'(rd_off) < count_q) && (32'(rd_ch) < NCH);

  sensor_frame_ram #(
    .NCH   (NCH),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sensor_data),
    .rd_addr_i (rd_slot),
    .rd_ch_i   (rd_ch),
    .rd_data_o (ram_rdata)
  );

  assign sctrl_out       = rd_valid ? ram_rdata : '0;
  assign sctrl_count     = count_q;
  assign sctrl_interrupt = (count_q >= NW'(IRQ_LEVEL));
  assign sctrl_overflow  = ovf_q;

endmodule

// File: tb/tb_sensor_frame_buf.sv
// Directed bench for sensor_frame_buf with a queue-based frame model checked every cycle.
module tb_sensor_frame_buf;
  import sensor_pkg::*;

  localparam int unsigned NCH       = 6;
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned IRQ_LEVEL = 4;
  localparam int unsigned CW        = 3;
  localparam int unsigned FW        = 2;
  localparam int unsigned NW        = 3;

  typedef logic [NCH*DW-1:0] frame_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic              sctrl_pop;
  logic              sctrl_mode;
  logic [FW+CW-1:0]  sctrl_addr;
  logic              sensor_ready;
  logic [NCH*DW-1:0] sensor_data;
  logic [DW-1:0]     sctrl_out;
  logic [NW-1:0]     sctrl_count;
  logic              sctrl_interrupt;
  logic              sctrl_overflow;
  logic              sensor_en;

  always #5 clk = ~clk;

  sensor_frame_buf #(
    .NCH       (NCH),
    .DW        (DW),
    .DEPTH     (DEPTH),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_pop       (sctrl_pop),
    .sctrl_mode      (sctrl_mode),
    .sctrl_addr      (sctrl_addr),
    .sensor_ready    (sensor_ready),
    .sensor_data     (sensor_data),
    .sctrl_out       (sctrl_out),
    .sctrl_count     (sctrl_count),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_overflow  (sctrl_overflow),
    .sensor_en       (sensor_en)
  );

  // Model: buffered frames oldest-first, plus last-cycle enable and mode.
  frame_t q[$];
  bit     m_ovf;
  bit     m_prev_en;
  bit     m_prev_mode;
  bit     chk_on = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic frame_t mkframe(input int k);
    frame_t f;
    for (int i = 0; i < NCH; i++) begin
      f[i*DW +: DW] = 32'h100 + 32'(i) + (32'(k) << 12);
    end
    return f;
  endfunction

  function automatic bit m_sensor_en();
    bit stopped;
    stopped = (q.size() == DEPTH) && (m_prev_mode == MODE_STOP);
    return m_prev_en && !stopped && sctrl_en && !sctrl_clear;
  endfunction

  function automatic logic [DW-1:0] m_out();
    int off;
    int ch;
    off = int'(sctrl_addr[FW+CW-1:CW]);
    ch  = int'(sctrl_addr[CW-1:0]);
    if (off < q.size() && ch < NCH) return q[off][ch*DW +: DW];
    return '0;
  endfunction

  task automatic model_step();
    bit do_push;
    bit do_pop;
    if (rst) begin
      q.delete();
      m_ovf       = 1'b0;
      m_prev_en   = 1'b0;
      m_prev_mode = 1'b0;
    end else begin
      do_push = m_sensor_en() && sensor_ready;
      do_pop  = sctrl_pop && (q.size() > 0);
      if (sctrl_clear) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        if (do_push) begin
          if (q.size() == DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
          end
          q.push_back(sensor_data);
        end
        if (do_pop) void'(q.pop_front());
      end
      m_prev_en   = sctrl_en;
      m_prev_mode = sctrl_mode;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", 32'(sctrl_count), 32'(q.size()));
      chk("interrupt", 32'(sctrl_interrupt), 32'(q.size() >= IRQ_LEVEL));
      chk("overflow", 32'(sctrl_overflow), 32'(m_ovf));
      chk("sensor_en", 32'(sensor_en), 32'(m_sensor_en()));
      chk("out", sctrl_out, m_out());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic push_frame(input int k);
    sensor_data  = mkframe(k);
    sensor_ready = 1'b1;
    tick();
    sensor_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    sctrl_en     = 1'b0;
    sctrl_clear  = 1'b0;
    sctrl_pop    = 1'b0;
    sctrl_mode   = MODE_STOP;
    sctrl_addr   = '0;
    sensor_ready = 1'b0;
    sensor_data  = '0;
    tick();
    tick();
    rst    = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("lit_rst_count", 32'(sctrl_count), 32'd0);
    chk("lit_rst_en", 32'(sensor_en), 32'd0);
    chk("lit_rst_out", sctrl_out, 32'd0);

    sctrl_en = 1'b1;
    tick();
    chk("lit_armed_en", 32'(sensor_en), 32'd1);

    // Three frames, then read channel 5 of the newest
    for (int k = 0; k < 3; k++) push_frame(k);
    sctrl_addr = {2'd2, 3'd5};
    #1;
    chk("lit_3_count", 32'(sctrl_count), 32'd3);
    chk("lit_3_irq", 32'(sctrl_interrupt), 32'd0);
    chk("lit_3_out", sctrl_out, 32'h2105);

    // Stop-on-full
    push_frame(3);
    #1;
    chk("lit_full_count", 32'(sctrl_count), 32'd4);
    chk("lit_full_irq", 32'(sctrl_interrupt), 32'd1);
    chk("lit_full_en", 32'(sensor_en), 32'd0);
    push_frame(9);
    sctrl_addr = {2'd3, 3'd0};
    #1;
    chk("lit_ign_count", 32'(sctrl_count), 32'd4);
    chk("lit_ign_ovf", 32'(sctrl_overflow), 32'd0);
    chk("lit_ign_out", sctrl_out, 32'h3100);

    // Mode change while full only takes effect next cycle
    sctrl_mode = MODE_OVERWRITE;
    #1;
    chk("lit_mode_same_cyc", 32'(sensor_en), 32'd0);
    tick();
    chk("lit_mode_next_cyc", 32'(sensor_en), 32'd1);

    // Overwrite-oldest
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    for (int k = 0; k < 6; k++) push_frame(k);
    sctrl_addr = {2'd0, 3'd0};
    #1;
    chk("lit_ow_count", 32'(sctrl_count), 32'd4);
    chk("lit_ow_ovf", 32'(sctrl_overflow), 32'd1);
    chk("lit_ow_out", sctrl_out, 32'h2100);
    tick();
    tick();
    chk("lit_ow_sticky", 32'(sctrl_overflow), 32'd1);

    // Push and pop together on a full buffer
    sctrl_pop = 1'b1;
    push_frame(6);
    sctrl_pop = 1'b0;
    #1;
    chk("lit_fpp_count", 32'(sctrl_count), 32'd3);
    chk("lit_fpp_out", sctrl_out, 32'h4100);

    // Push and pop together below full
    sctrl_clear = 1'b1;
    tick();
    sctrl_clear = 1'b0;
    push_frame(7);
    push_frame(8);
    sctrl_pop = 1'b1;
    push_frame(9);
    sctrl_pop  = 1'b0;
    sctrl_addr = {2'd0, 3'd0};
    #1;
    chk("lit_pp_count", 32'(sctrl_count), 32'd2);
    chk("lit_pp_out", sctrl_out, 32'h8100);
    sctrl_addr = {2'd1, 3'd5};
    #1;
    chk("lit_pp_out1", sctrl_out, 32'h9105);
    sctrl_addr = {2'd3, 3'd1};
    #1;
    chk("lit_off_oob", sctrl_out, 32'd0);
    sctrl_addr = {2'd0, 3'd7};
    #1;
    chk("lit_ch_oob", sctrl_out, 32'd0);
    tick();

    // Drain, then pop on empty
    sctrl_pop = 1'b1;
    tick();
    tick();
    tick();
    sctrl_pop = 1'b0;
    #1;
    chk("lit_empty_pop", 32'(sctrl_count), 32'd0);

    // Clear beats simultaneous push and pop
    for (int k = 10; k < 15; k++) push_frame(k);
    sctrl_clear  = 1'b1;
    sctrl_pop    = 1'b1;
    sensor_ready = 1'b1;
    sensor_data  = mkframe(15);
    #1;
    chk("lit_clr_en", 32'(sensor_en), 32'd0);
    tick();
    sctrl_clear  = 1'b0;
    sctrl_pop    = 1'b0;
    sensor_ready = 1'b0;
    #1;
    chk("lit_clr_count", 32'(sctrl_count), 32'd0);
    chk("lit_clr_ovf", 32'(sctrl_overflow), 32'd0);

    // Reset mid-capture
    for (int k = 16; k < 21; k++) push_frame(k);
    rst          = 1'b1;
    sensor_ready = 1'b1;
    sensor_data  = mkframe(21);
    tick();
    sensor_ready = 1'b0;
    sctrl_addr   = {2'd0, 3'd0};
    #1;
    chk("lit_rst2_count", 32'(sctrl_count), 32'd0);
    chk("lit_rst2_irq", 32'(sctrl_interrupt), 32'd0);
    chk("lit_rst2_ovf", 32'(sctrl_overflow), 32'd0);
    chk("lit_rst2_en", 32'(sensor_en), 32'd0);
    chk("lit_rst2_out", sctrl_out, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    push_frame(22);
    #1;
    chk("lit_after_count", 32'(sctrl_count), 32'd1);
    chk("lit_after_out", sctrl_out, 32'h16100);
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
